// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// and the width of the read-latency counter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Holds READ_LATENCY values up to 7.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed byte/half of a memory word and
// sign- or zero-extends it according to the RV32I load width code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_BU:   data = {24'd0, byte_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator on the single-port synchronous data memory.
// Optional build macro LSU_BOUNDS_CHECK_EN enables the out-of-range access fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE  = 12288,
  parameter int ADDR_WIDTH   = $clog2(MEMORY_SIZE),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byteena,
  input  logic [31:0]           mem_rdata
);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;

  logic             f3_legal;
  logic             misaligned;
  logic             bounds_fault;
  logic [3:0]       st_byteena;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign req_ready = (state == IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
  assign bounds_fault = (req_addr >= 32'(MEMORY_SIZE));
`else
  logic unused_addr_hi;
  assign bounds_fault   = 1'b0;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];
`endif

  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !req_is_store;
      default:          f3_legal = 1'b0;
    endcase

    misaligned = !f3_legal
               || ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    // Store lane steering: replicate the source so any enabled lane sees it.
    case (req_funct3[1:0])
      2'b00: begin
        st_byteena = 4'b0001 << req_addr[1:0];
        st_wdata   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_byteena = 4'b0011 << {req_addr[1], 1'b0};
        st_wdata   = {2{req_wdata[15:0]}};
      end
      default: begin
        st_byteena = 4'b1111;
        st_wdata   = req_wdata;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      is_store_q      <= 1'b0;
      funct3_q        <= '0;
      addr_lo_q       <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      mem_wdata       <= '0;
      mem_byteena     <= '0;
    end else begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      mem_byteena     <= '0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
            end else if (bounds_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              state       <= ISSUE;
              mem_addr    <= req_addr[ADDR_WIDTH-1:0];
              mem_we      <= req_is_store;
              mem_re      <= !req_is_store;
              mem_byteena <= req_is_store ? st_byteena : 4'b1111;
              mem_wdata   <= st_wdata;
              is_store_q  <= req_is_store;
              funct3_q    <= req_funct3;
              addr_lo_q   <= req_addr[1:0];
            end
          end
        end
        ISSUE: begin
          if (is_store_q) begin
            resp_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt   <= CNT_W'(READ_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          // Last WAIT cycle is the one in which mem_rdata is valid.
          if (cnt == CNT_W'(1)) begin
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-abort
// sequence and randomized requests against a byte-array reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 12288;
  localparam int AW        = 14;
  localparam int RL        = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          resp_fault;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .MEMORY_SIZE  (MEM_BYTES),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_re          (mem_re),
    .mem_wdata       (mem_wdata),
    .mem_byteena     (mem_byteena),
    .mem_rdata       (mem_rdata)
  );

  // Bus-functional memory: address register + output register (latency 2).
  logic [31:0] bfm_mem [4096];
  logic [31:0] rd_pipe1, rd_pipe2, bfm_w;
  assign mem_rdata = rd_pipe2;

  always @(posedge clk) begin
    rd_pipe1 <= bfm_mem[mem_addr[13:2]];
    rd_pipe2 <= rd_pipe1;
    if (mem_we) begin
      bfm_w = bfm_mem[mem_addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) bfm_w[8*b +: 8] = mem_wdata[8*b +: 8];
      bfm_mem[mem_addr[13:2]] <= bfm_w;
    end
  end

  // Reference model: flat byte array, addressed modulo the memory port width.
  logic [7:0] ref_mem [16384];

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned p;
    logic [31:0] r;
    p = a & 32'h3FFF;
    r = 0;
    case (f3)
      3'd0: begin r = 32'(ref_mem[p]); if (r >= 128) r = r + 32'hFFFFFF00; end
      3'd1: begin r = 32'(ref_mem[p]) + 256 * 32'(ref_mem[p+1]); if (r >= 32768) r = r + 32'hFFFF0000; end
      3'd2: r = 32'(ref_mem[p]) + 256 * 32'(ref_mem[p+1]) + 65536 * 32'(ref_mem[p+2]) + 16777216 * 32'(ref_mem[p+3]);
      3'd4: r = 32'(ref_mem[p]);
      3'd5: r = 32'(ref_mem[p]) + 256 * 32'(ref_mem[p+1]);
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rd, output logic got_mis);
    bit legal, mis, fault, issued, seen;
    int size, exp_cycle;
    logic [31:0] exp_rd, exp_be, exp_wd;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis   = !legal || ((a % size) != 0);
    fault = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    fault = !mis && (a >= MEM_BYTES);
`endif
    issued    = !mis && !fault;
    exp_cycle = !issued ? 1 : (st ? 2 : 2 + RL);
    exp_rd    = (issued && !st) ? model_load(f3, a) : 32'd0;
    if (!st)            begin exp_be = 32'hF; exp_wd = 0; end
    else if (size == 1) begin exp_be = 32'd1 << (a % 4); exp_wd = wd[7:0] * 32'h01010101; end
    else if (size == 2) begin exp_be = 32'd3 << (a % 4); exp_wd = wd[15:0] * 32'h00010001; end
    else                begin exp_be = 32'hF; exp_wd = wd; end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("resp_idle", resp_valid, 0);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    got_rd = 0; got_mis = 0; seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      chk("mem_we", mem_we, (issued && st && c == 1) ? 1 : 0);
      chk("mem_re", mem_re, (issued && !st && c == 1) ? 1 : 0);
      if (issued && c == 1) begin
        chk("mem_addr", 32'(mem_addr), a & 32'h3FFF);
        chk("mem_byteena", 32'(mem_byteena), exp_be);
        if (st) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (resp_valid) begin
        seen = 1;
        chk("resp_cycle", c, exp_cycle);
        chk("resp_misaligned", resp_misaligned, mis);
        chk("resp_fault", resp_fault, fault);
        chk("resp_rdata", resp_rdata, exp_rd);
        got_rd  = resp_rdata;
        got_mis = resp_misaligned;
      end
    end
    if (!seen) chk("resp_timeout", 0, 1);

    if (issued && st)
      for (int i = 0; i < size; i++)
        ref_mem[(a & 32'h3FFF) + i] = 8'(wd >> (8 * i));
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] got_rd;
    logic        got_mis;

    for (int i = 0; i < 4096; i++)  bfm_mem[i] = 0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 0;

    tbl[0]  = '{1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0};
    tbl[1]  = '{1, 3'd0, 32'h13,   32'h000000A5, 32'h0,        0};
    tbl[2]  = '{0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFA5, 0};
    tbl[3]  = '{0, 3'd4, 32'h13,   32'h0,        32'h000000A5, 0};
    tbl[4]  = '{0, 3'd2, 32'h10,   32'h0,        32'hA5ADBEEF, 0};
    tbl[5]  = '{1, 3'd2, 32'h20,   32'h80017FFF, 32'h0,        0};
    tbl[6]  = '{0, 3'd1, 32'h22,   32'h0,        32'hFFFF8001, 0};
    tbl[7]  = '{0, 3'd5, 32'h22,   32'h0,        32'h00008001, 0};
    tbl[8]  = '{0, 3'd1, 32'h20,   32'h0,        32'h00007FFF, 0};
    tbl[9]  = '{0, 3'd2, 32'h21,   32'h0,        32'h0,        1};
    tbl[10] = '{1, 3'd1, 32'h03,   32'h1234,     32'h0,        1};
    tbl[11] = '{0, 3'd3, 32'h40,   32'h0,        32'h0,        1};
    tbl[12] = '{1, 3'd4, 32'h40,   32'h55,       32'h0,        1};
    tbl[13] = '{0, 3'd2, 32'h3000, 32'h0,        32'h0,        0};

    rst = 1'b1; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_byteena", 32'(mem_byteena), 0);

    foreach (tbl[i]) begin
      do_req(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, got_rd, got_mis);
      chk("tbl_rdata", got_rd, tbl[i].exp_rd);
      chk("tbl_misaligned", got_mis, tbl[i].exp_mis);
    end

    // Reset while a load is waiting on memory: the read is dropped silently.
    @(negedge clk);
    req_is_store = 0; req_funct3 = 3'd2; req_addr = 32'h40; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_re_t1", mem_re, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_re_t3", mem_re, 0);
    chk("abort_req_ready", req_ready, 1);
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_resp", resp_valid, 0);
      @(negedge clk);
    end

    for (int n = 0; n < 200; n++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] a;
      int sz;
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      do_req(st, f3, a, $urandom(), got_rd, got_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
